pwm_duty_sequencer: RTL

//  Duty-cycle controller that drives DC_bus of the multi-channel PWM generator.
//  - Host writes per-channel target duties over a valid/ready port.
//  - On each PWM period tick, every live duty steps toward its target by RAMP_STEP (soft-start/soft-stop).
//  - All new duties are committed together so channels change in the same cycle.
//  - E-stop forces every duty to 0.

---
 rtl/pwm_duty_sequencer_pkg.sv | 24 ++
 rtl/pwm_duty_sequencer_ramp_step.sv | 41 ++++
 rtl/pwm_duty_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared definitions for the PWM duty sequencer: default sizing, FSM encodings
// and the channel-index width helper.
package pwm_duty_sequencer_pkg;

  localparam int NPWM_DEF      = 5;
  localparam int RES_DEF       = 8;
  localparam int RAMP_STEP_DEF = 4;
  localparam bit RAMP_EN_DEF   = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Channel index width; a single channel still needs a 1-bit index port.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit of channel i inside a packed duty bus.
  function automatic int duty_lo(input int i, input int res);
    return i * res;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_ramp_step.sv
// Single-channel duty step toward a target, evaluated one bit wider than the
// duty so neither direction can wrap past 0 or full scale.
module pwm_ramp_step
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int Resolution = RES_DEF,
  parameter int RAMP_STEP  = RAMP_STEP_DEF,
  parameter bit RAMP_EN    = RAMP_EN_DEF
) (
  input  logic [Resolution-1:0] cur_i,
  input  logic [Resolution-1:0] tgt_i,
  output logic [Resolution-1:0] nxt_o
);

  localparam logic [Resolution:0] STEP_W = (Resolution + 1)'(RAMP_STEP);

  logic              up_s;
  logic [Resolution:0] diff_s;
  logic [Resolution:0] sum_s;
  logic [Resolution:0] dif_s;

  always_comb begin
    up_s  = (tgt_i >= cur_i);
    sum_s = {1'b0, cur_i} + STEP_W;
    dif_s = {1'b0, cur_i} - STEP_W;
    if (up_s) begin
      diff_s = {1'b0, tgt_i} - {1'b0, cur_i};
    end else begin
      diff_s = {1'b0, cur_i} - {1'b0, tgt_i};
    end
    // Within one step of the target we land on it exactly, so no overshoot.
    if (!RAMP_EN || (diff_s <= STEP_W)) begin
      nxt_o = tgt_i;
    end else if (up_s) begin
      nxt_o = sum_s[Resolution-1:0];
    end else begin
      nxt_o = dif_s[Resolution-1:0];
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer feeding the PWM generator: host-written targets are
// approached one ramp step per period tick, all channels committed together.
module pwm_duty_sequencer
  import pwm_duty_sequencer_pkg::*;
#(
  parameter int NPWM       = NPWM_DEF,
  parameter int Resolution = RES_DEF,
  parameter int RAMP_STEP  = RAMP_STEP_DEF,
  parameter bit RAMP_EN    = RAMP_EN_DEF,
  localparam int CHAN_W    = chan_w(NPWM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       period_tick,
  input  logic                       estop,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [CHAN_W-1:0]          wr_chan,
  input  logic [Resolution-1:0]      wr_duty,
  output logic [NPWM*Resolution-1:0] DC_bus,
  output logic                       busy,
  output logic                       settled,
  output logic                       wr_err,
  output logic                       overrun
);

  logic [1:0]            state_q, state_d;
  logic [CHAN_W-1:0]     idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  wr_err_q, wr_err_d;
  logic                  settled_q, settled_d;
  logic [Resolution-1:0] target_q [NPWM];
  logic [Resolution-1:0] target_d [NPWM];
  logic [Resolution-1:0] shadow_q [NPWM];
  logic [Resolution-1:0] shadow_d [NPWM];
  logic [Resolution-1:0] dc_q     [NPWM];
  logic [Resolution-1:0] dc_d     [NPWM];

  logic                  hs_s;
  logic                  chan_ok_s;
  logic                  last_idx_s;
  logic [Resolution-1:0] cur_s;
  logic [Resolution-1:0] tgt_s;
  logic [Resolution-1:0] step_s;

  assign wr_ready   = (state_q == ST_IDLE) && !estop;
  assign hs_s       = wr_valid && wr_ready;
  assign chan_ok_s  = ({1'b0, wr_chan} < (CHAN_W + 1)'(NPWM));
  assign last_idx_s = (idx_q == CHAN_W'(NPWM - 1));
  assign busy       = (state_q != ST_IDLE);
  assign settled    = settled_q;
  assign wr_err     = wr_err_q;
  assign overrun    = overrun_q;

  // Select the channel under scan for the shared step unit.
  always_comb begin
    cur_s = '0;
    tgt_s = '0;
    for (int i = 0; i < NPWM; i++) begin
      cur_s = cur_s | ((idx_q == CHAN_W'(i)) ? dc_q[i]     : '0);
      tgt_s = tgt_s | ((idx_q == CHAN_W'(i)) ? target_q[i] : '0);
    end
  end

  pwm_ramp_step #(
    .Resolution (Resolution),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_EN    (RAMP_EN)
  ) u_step (
    .cur_i (cur_s),
    .tgt_i (tgt_s),
    .nxt_o (step_s)
  );

  // Next-state logic: estop override, host writes, scan/commit sequencing.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    wr_err_d  = 1'b0;
    target_d  = target_q;
    shadow_d  = shadow_q;
    dc_d      = dc_q;

    if (estop) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
      for (int i = 0; i < NPWM; i++) begin
        target_d[i] = '0;
        shadow_d[i] = '0;
        dc_d[i]     = '0;
      end
    end else begin
      for (int i = 0; i < NPWM; i++) begin
        if (hs_s && chan_ok_s && (wr_chan == CHAN_W'(i))) begin
          target_d[i] = wr_duty;
        end else begin
          target_d[i] = target_q[i];
        end
      end
      wr_err_d = hs_s && !chan_ok_s;

      case (state_q)
        ST_IDLE: begin
          if (period_tick || pending_q) begin
            state_d   = ST_SCAN;
            idx_d     = '0;
            // A fresh tick arriving with a stale pending one keeps one queued.
            pending_d = period_tick && pending_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          for (int i = 0; i < NPWM; i++) begin
            if (idx_q == CHAN_W'(i)) begin
              shadow_d[i] = step_s;
            end else begin
              shadow_d[i] = shadow_q[i];
            end
          end
          if (last_idx_s) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + CHAN_W'(1);
          end
        end
        ST_COMMIT: begin
          dc_d    = shadow_q;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase

      if (period_tick && (state_q != ST_IDLE)) begin
        if (pending_q) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end else begin
        overrun_d = overrun_q;
      end
    end

    settled_d = 1'b1;
    for (int i = 0; i < NPWM; i++) begin
      settled_d = settled_d & (dc_d[i] == target_d[i]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_err_q  <= 1'b0;
      settled_q <= 1'b1;
      for (int i = 0; i < NPWM; i++) begin
        target_q[i] <= '0;
        shadow_q[i] <= '0;
        dc_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      wr_err_q  <= wr_err_d;
      settled_q <= settled_d;
      target_q  <= target_d;
      shadow_q  <= shadow_d;
      dc_q      <= dc_d;
    end
  end

  // Pack live duties onto the bus.
  always_comb begin
    DC_bus = '0;
    for (int i = 0; i < NPWM; i++) begin
      DC_bus[duty_lo(i, Resolution) +: Resolution] = dc_q[i];
    end
  end

endmodule
